// File: rtl/conv_window_feeder.sv
// conv_window_feeder: turns a raster pixel stream into 3x3 windows for the
// convolution engine. Two line buffers hold the previous two rows, and a
// 3x3 register array slides one column per accepted pixel. Only windows
// that lie fully inside the frame are emitted, so there is no padding.
module conv_window_feeder #(
    parameter int unsigned IMG_W = 16,
    parameter int unsigned IMG_H = 16
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    output logic [71:0] window,
    output logic        win_valid,
    input  logic        win_ready,
    output logic        frame_done
);

    localparam int unsigned PIX_W = 8;
    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Position of the next pixel to accept
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Position of the pixel on the input this cycle (sof forces the origin)
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;

    // Line buffers: lb0 holds row r-1, lb1 holds row r-2
    logic [PIX_W-1:0] lb0_q [IMG_W];
    logic [PIX_W-1:0] lb1_q [IMG_W];
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;

    // Sliding window, indexed [row][col]; row 0 is the top, col 0 the left
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];

    logic win_valid_q, win_valid_d;
    logic frame_done_q, frame_done_d;

    logic accept;
    logic win_due;
    logic last_pos;

    // Input handshake: a held window blocks new pixels so it cannot be shifted out
    assign pix_ready = !win_valid_q || win_ready;
    assign accept    = pix_valid && pix_ready;

    // Current pixel position and what it implies for the window output
    always_comb begin
        cur_col  = pix_sof ? '0 : col_q;
        cur_row  = pix_sof ? '0 : row_q;
        lb0_rd   = lb0_q[cur_col];
        lb1_rd   = lb1_q[cur_col];
        win_due  = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
        last_pos = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));
    end

    // Next-state logic for counters, window registers and output flags
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        frame_done_d = 1'b0;

        if (accept) begin
            if (cur_col == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end

            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = pix_in;

            win_valid_d  = win_due;
            frame_done_d = win_due && last_pos;
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // Control and window registers
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // Line buffers need no reset: rows 0 and 1 refill them before any window reads them
    always_ff @(posedge clk1) begin
        if (accept) begin
            lb1_q[cur_col] <= lb0_rd;
            lb0_q[cur_col] <= pix_in;
        end
    end

    assign window     = {win_q[0][0], win_q[0][1], win_q[0][2],
                         win_q[1][0], win_q[1][1], win_q[1][2],
                         win_q[2][0], win_q[2][1], win_q[2][2]};
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Testbench for conv_window_feeder with a 4x4 image: directed scenarios with
// hand-computed windows plus a frame-level reference model on a monitor.
module tb_conv_window_feeder;

    localparam int unsigned W = 4;
    localparam int unsigned H = 4;

    localparam logic [71:0] WIN_F0_FIRST = 72'h00_01_02_04_05_06_08_09_0A;
    localparam logic [71:0] WIN_F0_SEC   = 72'h01_02_03_05_06_07_09_0A_0B;
    localparam logic [71:0] WIN_F0_LAST  = 72'h05_06_07_09_0A_0B_0D_0E_0F;
    localparam logic [71:0] WIN_F1_FIRST = 72'h10_11_12_14_15_16_18_19_1A;
    localparam logic [71:0] WIN_F1_LAST  = 72'h15_16_17_19_1A_1B_1D_1E_1F;

    logic        clk1;
    logic        rst_n;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic [71:0] window;
    logic        win_valid;
    logic        win_ready;
    logic        frame_done;

    int n_tests;
    int n_fail;
    int win_cnt;
    int fd_cnt;
    bit rnd_ready;

    conv_window_feeder #(.IMG_W(W), .IMG_H(H)) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .window     (window),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that accepted the pixel
    task automatic push_pix(input logic [7:0] v, input logic sof);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        pix_in    = v;
        pix_sof   = sof;
        pix_valid = 1'b1;
        while (!done) begin
            if (rnd_ready) win_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk1);
            done = pix_ready;
            @(posedge clk1);
            #1;
            if (!done) begin
                n++;
                if (n >= 200) begin
                    check("push_timeout", 72'(0), 72'(1));
                    done = 1'b1;
                end
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic push_range(input int first, input int last, input logic sof_first);
        for (int i = first; i <= last; i++) begin
            push_pix(8'(i), sof_first && (i == first));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (rnd_ready) win_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk1);
            #1;
        end
    endtask

    // Reference model: tracks raster position, stores the frame and predicts windows
    logic [71:0] exp_w_q[$];
    logic        exp_fd_q[$];

    initial begin : monitor
        int          mcol;
        int          mrow;
        logic [7:0]  mpix [H][W];
        logic        prev_hold;
        logic [71:0] held_w;
        logic [71:0] e_w;
        logic        e_fd;
        mcol      = 0;
        mrow      = 0;
        prev_hold = 1'b0;
        held_w    = '0;
        forever begin
            @(negedge clk1);
            if (!rst_n) begin
                mcol      = 0;
                mrow      = 0;
                prev_hold = 1'b0;
                exp_w_q.delete();
                exp_fd_q.delete();
            end else begin
                check("pix_ready_rule", 72'(pix_ready), 72'(!win_valid || win_ready));
                if (frame_done) fd_cnt++;
                if (win_valid && !prev_hold) begin
                    win_cnt++;
                    if (exp_w_q.size() == 0) begin
                        check("unexpected_window", 72'(1), 72'(0));
                    end else begin
                        e_w  = exp_w_q.pop_front();
                        e_fd = exp_fd_q.pop_front();
                        check("model_window", window, e_w);
                        check("model_frame_done", 72'(frame_done), 72'(e_fd));
                    end
                end else if (frame_done) begin
                    check("frame_done_stray", 72'(frame_done), 72'(0));
                end
                if (prev_hold) check("hold_window", window, held_w);
                prev_hold = win_valid && !win_ready;
                held_w    = window;
                if (pix_valid && pix_ready) begin
                    if (pix_sof) begin
                        mcol = 0;
                        mrow = 0;
                    end
                    mpix[mrow][mcol] = pix_in;
                    if (mrow >= 2 && mcol >= 2) begin
                        exp_w_q.push_back({mpix[mrow-2][mcol-2], mpix[mrow-2][mcol-1], mpix[mrow-2][mcol],
                                           mpix[mrow-1][mcol-2], mpix[mrow-1][mcol-1], mpix[mrow-1][mcol],
                                           mpix[mrow][mcol-2],   mpix[mrow][mcol-1],   mpix[mrow][mcol]});
                        exp_fd_q.push_back((mrow == H - 1) && (mcol == W - 1));
                    end
                    if (mcol == W - 1) begin
                        mcol = 0;
                        mrow = (mrow == H - 1) ? 0 : mrow + 1;
                    end else begin
                        mcol++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d tests expected completion", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int w0;
        int f0;
        n_tests   = 0;
        n_fail    = 0;
        win_cnt   = 0;
        fd_cnt    = 0;
        rnd_ready = 1'b0;
        rst_n     = 1'b1;
        pix_in    = '0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        win_ready = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_win_valid", 72'(win_valid), 72'(0));
        check("rst_frame_done", 72'(frame_done), 72'(0));
        check("rst_pix_ready", 72'(pix_ready), 72'(1));
        check("rst_window", window, 72'(0));
        repeat (2) @(posedge clk1);
        #1 rst_n = 1'b1;
        @(posedge clk1);
        #1;

        // Plain frame 0..15 with win_ready held high
        w0 = win_cnt; f0 = fd_cnt;
        push_range(0, 9, 1'b1);
        check("f0_no_win_col1", 72'(win_valid), 72'(0));
        push_pix(8'd10, 1'b0);
        check("f0_first_valid", 72'(win_valid), 72'(1));
        check("f0_first_win", window, WIN_F0_FIRST);
        check("f0_first_fd", 72'(frame_done), 72'(0));
        push_range(11, 15, 1'b0);
        check("f0_last_win", window, WIN_F0_LAST);
        check("f0_last_fd", 72'(frame_done), 72'(1));
        idle(1);
        check("f0_fd_pulse", 72'(frame_done), 72'(0));
        check("f0_valid_drop", 72'(win_valid), 72'(0));
        idle(1);
        check("f0_win_count", 72'(win_cnt - w0), 72'(4));
        check("f0_fd_count", 72'(fd_cnt - f0), 72'(1));

        // Downstream stall for 5 cycles on the first window
        w0 = win_cnt; f0 = fd_cnt;
        push_range(0, 10, 1'b1);
        win_ready = 1'b0;
        pix_in    = 8'd11;
        pix_valid = 1'b1;
        repeat (5) begin
            @(negedge clk1);
            check("stall_pix_ready", 72'(pix_ready), 72'(0));
            check("stall_valid", 72'(win_valid), 72'(1));
            check("stall_window", window, WIN_F0_FIRST);
            @(posedge clk1);
            #1;
        end
        win_ready = 1'b1;
        push_pix(8'd11, 1'b0);
        check("stall_no_bubble", 72'(win_valid), 72'(1));
        check("stall_second_win", window, WIN_F0_SEC);
        push_range(12, 15, 1'b0);
        check("stall_last_win", window, WIN_F0_LAST);
        idle(2);
        check("stall_win_count", 72'(win_cnt - w0), 72'(4));
        check("stall_fd_count", 72'(fd_cnt - f0), 72'(1));

        // Two back-to-back frames
        w0 = win_cnt; f0 = fd_cnt;
        push_range(0, 15, 1'b1);
        push_range(16, 26, 1'b1);
        check("f1_first_win", window, WIN_F1_FIRST);
        push_range(27, 31, 1'b0);
        check("f1_last_win", window, WIN_F1_LAST);
        check("f1_last_fd", 72'(frame_done), 72'(1));
        idle(2);
        check("b2b_win_count", 72'(win_cnt - w0), 72'(8));
        check("b2b_fd_count", 72'(fd_cnt - f0), 72'(2));

        // sof on pixel 6 restarts the frame
        w0 = win_cnt; f0 = fd_cnt;
        push_range(0, 5, 1'b1);
        push_range(0, 10, 1'b1);
        check("sof_first_win", window, WIN_F0_FIRST);
        push_range(11, 15, 1'b0);
        check("sof_last_win", window, WIN_F0_LAST);
        idle(2);
        check("sof_win_count", 72'(win_cnt - w0), 72'(4));
        check("sof_fd_count", 72'(fd_cnt - f0), 72'(1));

        // Reset mid-frame while a window is held
        push_range(0, 10, 1'b1);
        check("prerst_valid", 72'(win_valid), 72'(1));
        win_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_win_valid", 72'(win_valid), 72'(0));
        check("midrst_pix_ready", 72'(pix_ready), 72'(1));
        check("midrst_frame_done", 72'(frame_done), 72'(0));
        check("midrst_window", window, 72'(0));
        repeat (2) @(posedge clk1);
        #3 rst_n = 1'b1;
        #1;
        check("rel_win_valid", 72'(win_valid), 72'(0));
        @(posedge clk1);
        #1;
        win_ready = 1'b1;
        w0 = win_cnt; f0 = fd_cnt;
        push_range(0, 10, 1'b0);
        check("postrst_first_win", window, WIN_F0_FIRST);
        push_range(11, 15, 1'b0);
        check("postrst_last_fd", 72'(frame_done), 72'(1));
        idle(2);
        check("postrst_win_count", 72'(win_cnt - w0), 72'(4));
        check("postrst_fd_count", 72'(fd_cnt - f0), 72'(1));

        // Random valid gaps and downstream back-pressure over 100 frames
        w0 = win_cnt; f0 = fd_cnt;
        rnd_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < 16; i++) begin
                idle(int'($urandom_range(0, 2)));
                push_pix(8'($urandom_range(0, 255)), i == 0);
            end
        end
        rnd_ready = 1'b0;
        win_ready = 1'b1;
        idle(3);
        check("rand_win_count", 72'(win_cnt - w0), 72'(400));
        check("rand_fd_count", 72'(fd_cnt - f0), 72'(100));
        check("rand_queue_empty", 72'(exp_w_q.size()), 72'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
